// File: rtl/flac_pkg.sv
// Shared FLAC decode definitions: channel-assignment codes, decorrelator
// state encoding and default datapath sizes.
package flac_pkg;

  localparam int SAMPLE_W_DEF  = 16;
  localparam int MAX_BLOCK_DEF = 4096;

  localparam logic [3:0] CH_INDEPENDENT = 4'd1;
  localparam logic [3:0] CH_LEFT_SIDE   = 4'd8;
  localparam logic [3:0] CH_RIGHT_SIDE  = 4'd9;
  localparam logic [3:0] CH_MID_SIDE    = 4'd10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CH0   = 2'd1;
  localparam state_t ST_CH1   = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/decorr_sample_buffer.sv
// Simple dual-port sample buffer holding one channel-0 subframe.
// Registered read with one cycle of latency; a same-address read and write returns the old word.
module decorr_sample_buffer #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 17,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stereo_decorrelator.sv
// Buffers the channel-0 subframe, pairs it with channel 1 and undoes FLAC stereo decorrelation.
// Optional build macro DECORR_RANGE_CHECK_EN saturates out-of-range results and flags oError.
module stereo_decorrelator
  import flac_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int MAX_BLOCK = MAX_BLOCK_DEF,
  parameter int ADDR_W    = $clog2(MAX_BLOCK)
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iEnable,
  input  logic [3:0]                 iChannelAssign,
  input  logic [15:0]                iBlockSize,
  input  logic                       iSampleValid,
  input  logic signed [SAMPLE_W:0]   iSample,
  output logic signed [SAMPLE_W-1:0] oLeft,
  output logic signed [SAMPLE_W-1:0] oRight,
  output logic                       oValid,
  output logic                       oBlockDone,
  output logic                       oError
);

  localparam int EXT_W = SAMPLE_W + 2;

  state_t            state;
  logic [3:0]        mode;
  logic [ADDR_W:0]   blk_len;
  logic [ADDR_W:0]   idx;
  logic              accept, idx_last, wr_en, rd_en;
  logic              code_ok, start_bad;
  logic [SAMPLE_W:0] c0_q;
  logic [SAMPLE_W:0] c1_r;
  logic              s1_valid, s1_last;

  logic signed [EXT_W-1:0]    c0_x, c1_x, m, sum_l, sum_r, res_l, res_r;
  logic signed [SAMPLE_W-1:0] out_l, out_r;
`ifdef DECORR_RANGE_CHECK_EN
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] MIN_V = -MAX_V - 1;
  logic ovf;
`endif

  assign accept   = iSampleValid & iEnable;
  assign idx_last = (idx + 1'b1) == blk_len;
  assign wr_en    = accept && (state == ST_CH0);
  assign rd_en    = accept && (state == ST_CH1);

  always_comb begin
    code_ok = 1'b0;
    case (iChannelAssign)
      CH_INDEPENDENT, CH_LEFT_SIDE, CH_RIGHT_SIDE, CH_MID_SIDE: code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  assign start_bad = !code_ok || (iBlockSize == '0) || (int'(iBlockSize) > MAX_BLOCK);

  decorr_sample_buffer #(
    .DEPTH(MAX_BLOCK),
    .WIDTH(SAMPLE_W + 1),
    .AW   (ADDR_W)
  ) u_buf (
    .clk    (iClock),
    .wr_en  (wr_en),
    .wr_addr(idx[ADDR_W-1:0]),
    .wr_data(iSample),
    .rd_en  (rd_en),
    .rd_addr(idx[ADDR_W-1:0]),
    .rd_data(c0_q)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    c0_x  = {c0_q[SAMPLE_W], c0_q};
    c1_x  = {c1_r[SAMPLE_W], c1_r};
    m     = {c0_x[EXT_W-2:0], c1_x[0]};
    sum_l = c0_x;
    sum_r = c1_x;
    res_l = c0_x;
    res_r = c1_x;
    case (mode)
      CH_LEFT_SIDE: begin
        res_r = c0_x - c1_x;
      end
      CH_RIGHT_SIDE: begin
        res_l = c0_x + c1_x;
      end
      CH_MID_SIDE: begin
        // Mid was stored halved; the side LSB restores the bit lost by that halving.
        sum_l = m + c1_x;
        sum_r = m - c1_x;
        res_l = sum_l >>> 1;
        res_r = sum_r >>> 1;
      end
      default: ;
    endcase
`ifdef DECORR_RANGE_CHECK_EN
    ovf   = 1'b0;
    out_l = SAMPLE_W'(res_l);
    out_r = SAMPLE_W'(res_r);
    if (res_l > MAX_V)      begin out_l = SAMPLE_W'(MAX_V); ovf = 1'b1; end
    else if (res_l < MIN_V) begin out_l = SAMPLE_W'(MIN_V); ovf = 1'b1; end
    if (res_r > MAX_V)      begin out_r = SAMPLE_W'(MAX_V); ovf = 1'b1; end
    else if (res_r < MIN_V) begin out_r = SAMPLE_W'(MIN_V); ovf = 1'b1; end
`else
    out_l = SAMPLE_W'(res_l);
    out_r = SAMPLE_W'(res_r);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= ST_IDLE;
      mode       <= '0;
      blk_len    <= '0;
      idx        <= '0;
      c1_r       <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      oLeft      <= '0;
      oRight     <= '0;
      oValid     <= 1'b0;
      oBlockDone <= 1'b0;
      oError     <= 1'b0;
    end else begin
      s1_valid   <= rd_en;
      s1_last    <= rd_en & idx_last;
      if (rd_en) c1_r <= iSample;
      oValid     <= s1_valid;
      oBlockDone <= s1_valid & s1_last;
      if (s1_valid) begin
        oLeft  <= out_l;
        oRight <= out_r;
      end
`ifdef DECORR_RANGE_CHECK_EN
      if (s1_valid && ovf) oError <= 1'b1;
`endif
      case (state)
        ST_IDLE: if (iEnable) begin
          mode    <= iChannelAssign;
          blk_len <= iBlockSize[ADDR_W:0];
          idx     <= '0;
          oError  <= start_bad;
          if (!start_bad) state <= ST_CH0;
        end
        ST_CH0: if (wr_en) begin
          idx <= idx_last ? '0 : idx + 1'b1;
          if (idx_last) state <= ST_CH1;
        end
        ST_CH1: if (rd_en) begin
          idx <= idx_last ? '0 : idx + 1'b1;
          if (idx_last) state <= ST_DRAIN;
        end
        default: if (oBlockDone) state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_decorrelator.sv
// Directed self-checking bench for stereo_decorrelator with hand-computed expected pairs.
// Expectations for the overflow frame follow the DECORR_RANGE_CHECK_EN build setting.
module tb_stereo_decorrelator;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iEnable;
  logic [3:0]         iChannelAssign;
  logic [15:0]        iBlockSize;
  logic               iSampleValid;
  logic signed [16:0] iSample;
  logic signed [15:0] oLeft;
  logic signed [15:0] oRight;
  logic               oValid;
  logic               oBlockDone;
  logic               oError;

  typedef struct {
    int l;
    int r;
    int done;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   pairs_seen, done_seen;
  int   first_valid_cyc, last_valid_cyc, ch1_first_cyc;
  int   ch0_q[$];
  int   ch1_q[$];
  exp_t exp_q[$];

  always #5 iClock = ~iClock;

  stereo_decorrelator dut (
    .iClock        (iClock),
    .iReset        (iReset),
    .iEnable       (iEnable),
    .iChannelAssign(iChannelAssign),
    .iBlockSize    (iBlockSize),
    .iSampleValid  (iSampleValid),
    .iSample       (iSample),
    .oLeft         (oLeft),
    .oRight        (oRight),
    .oValid        (oValid),
    .oBlockDone    (oBlockDone),
    .oError        (oError)
  );

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic push(input int l, input int r, input int done);
    exp_t e;
    e.l = l; e.r = r; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    if (oBlockDone) done_seen++;
    if (oValid) begin
      if (pairs_seen == 0) first_valid_cyc = cyc;
      last_valid_cyc = cyc;
      pairs_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("left", int'(oLeft), e.l);
        check("right", int'(oRight), e.r);
        check("block_done", int'(oBlockDone), e.done);
      end
    end else if (oBlockDone) begin
      check("done_without_valid", 1, 0);
    end
  endtask

  // Sample outputs on the falling edge, then drive the next cycle's inputs.
  task automatic step(input logic en, input logic v, input int s);
    @(negedge iClock);
    cyc++;
    observe();
    iEnable      = en;
    iSampleValid = v;
    iSample      = 17'(s);
  endtask

  // Runs one full frame from ch0_q/ch1_q; hold inserts disabled junk strobes during ch0.
  task automatic run_frame(input logic [3:0] code, input int n, input int hold);
    pairs_seen = 0;
    done_seen  = 0;
    iChannelAssign = code;
    iBlockSize     = 16'(n);
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < n; i++) begin
      if (i == 1) repeat (hold) step(1'b0, 1'b1, 999);
      step(1'b1, 1'b1, ch0_q[i]);
      if (i == 0) check("err_cleared_on_start", int'(oError), 0);
    end
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, ch1_q[i]);
      if (i == 0) ch1_first_cyc = cyc;
    end
    step(1'b0, 1'b0, 0);
    for (int k = 0; k < 8 && done_seen == 0; k++) step(1'b0, 1'b0, 0);
    check("done_count", done_seen, 1);
    check("pair_count", pairs_seen, n);
    check("latency", first_valid_cyc - ch1_first_cyc, 2);
    check("throughput", last_valid_cyc - first_valid_cyc, n - 1);
    ch0_q.delete();
    ch1_q.delete();
  endtask

  task automatic bad_start(input string tag, input logic [3:0] code, input int n);
    pairs_seen = 0;
    iChannelAssign = code;
    iBlockSize     = 16'(n);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 5);
    check(tag, int'(oError), 1);
    repeat (3) step(1'b1, 1'b1, 5);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    check({tag, "_sticky"}, int'(oError), 1);
    check({tag, "_no_valid"}, pairs_seen, 0);
  endtask

  initial begin
    iReset = 1'b1; iEnable = 1'b0; iChannelAssign = '0;
    iBlockSize = '0; iSampleValid = 1'b0; iSample = '0;
    repeat (2) @(negedge iClock);
    check("reset_valid", int'(oValid), 0);
    check("reset_left", int'(oLeft), 0);
    check("reset_right", int'(oRight), 0);
    check("reset_error", int'(oError), 0);
    iReset = 1'b0;

    // Mid/side, block 2.
    ch0_q = '{70, 70}; ch1_q = '{60, 61};
    push(100, 40, 0); push(101, 40, 1);
    run_frame(4'd10, 2, 0);

    bad_start("err_code_11", 4'd11, 2);

    // Left/side, block 1; also clears the error.
    ch0_q = '{-5}; ch1_q = '{-8};
    push(-5, 3, 1);
    run_frame(4'd8, 1, 0);

    bad_start("err_size_0", 4'd1, 0);

    // Right/side, block 1.
    ch0_q = '{-8}; ch1_q = '{3};
    push(-5, 3, 1);
    run_frame(4'd9, 1, 0);

    bad_start("err_size_4097", 4'd1, 4097);

    // Mid/side with negative odd side exercises the arithmetic shift.
    ch0_q = '{-3}; ch1_q = '{-5};
    push(-5, 0, 1);
    run_frame(4'd10, 1, 0);

    // Independent with iEnable dropped mid-channel-0 while strobes keep coming.
    ch0_q = '{7, -9}; ch1_q = '{11, 12};
    push(7, 11, 0); push(-9, 12, 1);
    run_frame(4'd1, 2, 2);

    // Reset during CH1 once three pairs have come out.
    pairs_seen = 0; done_seen = 0;
    iChannelAssign = 4'd1; iBlockSize = 16'd8;
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 100 + i);
    push(100, -200, 0); push(101, -201, 0); push(102, -202, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, -(200 + i));
    check("pairs_before_reset", pairs_seen, 3);
    #2 iReset = 1'b1;
    #1;
    check("async_reset_valid", int'(oValid), 0);
    check("async_reset_left", int'(oLeft), 0);
    check("async_reset_right", int'(oRight), 0);
    check("async_reset_done", int'(oBlockDone), 0);
    exp_q.delete();
    @(negedge iClock);
    iReset = 1'b0; iEnable = 1'b0; iSampleValid = 1'b0;
    step(1'b0, 1'b0, 0);
    check("no_partial_pair", int'(oValid), 0);

    // Mid/side near full scale after reset: R = 32768 is out of range.
    ch0_q = '{32767}; ch1_q = '{-2};
`ifdef DECORR_RANGE_CHECK_EN
    push(32766, 32767, 1);
    run_frame(4'd10, 1, 0);
    check("range_error", int'(oError), 1);
`else
    push(32766, -32768, 1);
    run_frame(4'd10, 1, 0);
    check("range_error", int'(oError), 0);
`endif

    // Independent, maximum block, back-to-back strobes.
    for (int i = 0; i < 4096; i++) begin
      ch0_q.push_back(i);
      ch1_q.push_back(-i);
      push(i, -i, (i == 4095) ? 1 : 0);
    end
    run_frame(4'd1, 4096, 0);

    // Back in IDLE: a short frame must decode straight away.
    ch0_q = '{1}; ch1_q = '{2};
    push(1, 2, 1);
    run_frame(4'd1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
